// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Configurable UART receiver with a 16x oversampling front end, 3-sample
// majority voting, parity/framing/break detection and a small show-ahead
// receive FIFO with a valid/ready pop interface.
//
// Ports:
//   clk_i         system clock
//   rst_n         asynchronous active-low reset
//   uart_rx_i     asynchronous serial line (idle high)
//   baud_div_i    oversample tick period minus 1
//   data_bits_i   00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i   parity bit present
//   parity_odd_i  1 = odd parity, 0 = even parity
//   stop2_i       two stop bits
//   rx_data_o     FIFO head data (LSB-aligned, unused upper bits 0)
//   rx_perr_o     parity error flag of FIFO head
//   rx_ferr_o     framing error flag of FIFO head
//   rx_valid_o    FIFO not empty
//   rx_ready_i    pop request (pop when rx_valid_o & rx_ready_i)
//   break_o       one-cycle pulse when a break is detected
//   overrun_o     sticky: a frame was dropped because the FIFO was full
//   clr_err_i     clears overrun_o
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             uart_rx_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic [1:0]       data_bits_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_perr_o,
    output logic             rx_ferr_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             break_o,
    output logic             overrun_o,
    input  logic             clr_err_i
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRKWAIT
    } state_t;

    // -------------------------------------------------------------------------
    // Line synchronizer and falling-edge detect
    // -------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic w_line;
    logic w_fall;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = r_sync3 & ~r_sync2;

    // -------------------------------------------------------------------------
    // Frame state
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [1:0]         r_dbits;
    logic               r_par_en;
    logic               r_par_odd;
    logic               r_stop2;
    logic [DIV_W-1:0]   r_tick_cnt;
    logic [3:0]         r_sub;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_data;
    logic               r_perr;
    logic               r_ferr;
    logic               r_par_bit;
    logic               r_stop0;
    logic               r_s7;
    logic               r_s8;
    logic               r_break;

    logic               w_tick;
    logic               w_maj;
    logic               w_decide;
    logic               w_bit_end;
    logic               w_last_data;
    logic               w_last_stop;
    logic               w_done;
    logic               w_stop0;
    logic               w_is_break;
    logic               w_ferr_fin;
    logic               w_push;
    logic [9:0]         w_push_word;

    // -------------------------------------------------------------------------
    // Oversample tick generator. Loading the live divisor on the start edge
    // makes the first tick land divisor+1 clocks after detection.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_fall) begin
                r_tick_cnt <= baud_div_i;
            end else begin
                r_tick_cnt <= r_div;
            end
        end else if (r_tick_cnt == '0) begin
            r_tick_cnt <= r_div;
        end else begin
            r_tick_cnt <= r_tick_cnt - 1'b1;
        end
    end

    assign w_tick      = (r_state != S_IDLE) && (r_tick_cnt == '0);
    // Third sample is the live line value at sub 9; first two were stored.
    assign w_maj       = (r_s7 & r_s8) | (r_s7 & w_line) | (r_s8 & w_line);
    assign w_decide    = w_tick && (r_sub == 4'd9);
    assign w_bit_end   = w_tick && (r_sub == 4'd15);
    // Last data bit index is (bits - 1) = 4 + data_bits.
    assign w_last_data = (r_bit_idx == {1'b1, r_dbits});
    assign w_last_stop = (r_state == S_STOP) && (r_stop_idx == r_stop2);
    assign w_done      = w_decide && w_last_stop;

    // The first stop bit is still being decided when only one stop bit is used.
    assign w_stop0     = (r_stop_idx == 1'b0) ? w_maj : r_stop0;
    assign w_is_break  = (r_data == 8'd0) && (!r_par_en || !r_par_bit) && !w_stop0;
    assign w_ferr_fin  = r_ferr | ~w_maj;
    assign w_push      = w_done && !w_is_break;
    assign w_push_word = {w_ferr_fin, r_perr, r_data};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_dbits    <= 2'd0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_sub      <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_data     <= 8'd0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop0    <= 1'b1;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_break    <= 1'b0;
        end else begin
            r_break <= 1'b0;

            if (w_tick) begin
                r_sub <= r_sub + 4'd1;
            end
            if (w_tick && (r_sub == 4'd7)) begin
                r_s7 <= w_line;
            end
            if (w_tick && (r_sub == 4'd8)) begin
                r_s8 <= w_line;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        // Configuration is frozen for the whole frame.
                        r_div      <= baud_div_i;
                        r_dbits    <= data_bits_i;
                        r_par_en   <= parity_en_i;
                        r_par_odd  <= parity_odd_i;
                        r_stop2    <= stop2_i;
                        r_sub      <= 4'd0;
                        r_bit_idx  <= 3'd0;
                        r_stop_idx <= 1'b0;
                        r_data     <= 8'd0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_par_bit  <= 1'b0;
                        r_stop0    <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_decide && w_maj) begin
                        // Glitch, not a start bit: drop silently.
                        r_state <= S_IDLE;
                    end else if (w_bit_end) begin
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_decide) begin
                        r_data[r_bit_idx] <= w_maj;
                    end
                    if (w_bit_end) begin
                        if (w_last_data) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_decide) begin
                        r_par_bit <= w_maj;
                        r_perr    <= w_maj ^ (^r_data) ^ r_par_odd;
                    end
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (w_decide) begin
                        if (!w_maj) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_stop_idx == 1'b0) begin
                            r_stop0 <= w_maj;
                        end
                        if (w_last_stop) begin
                            // Frame ends at the last stop decision so an early
                            // start edge in the rest of the stop bit is seen.
                            if (w_is_break) begin
                                r_break <= 1'b1;
                                r_state <= S_BRKWAIT;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (w_bit_end) begin
                        r_stop_idx <= 1'b1;
                    end
                end

                S_BRKWAIT: begin
                    if (w_line) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign break_o = r_break;

    // -------------------------------------------------------------------------
    // Receive FIFO: {ferr, perr, data[7:0]} per entry, head held in registers
    // -------------------------------------------------------------------------
    logic [9:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [9:0]         r_head;
    logic               r_valid;
    logic               r_overrun;

    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    logic               w_ovr_set;
    logic [FIFO_AW-1:0] w_rptr_inc;
    logic [FIFO_AW:0]   w_count_next;

    assign w_pop        = r_valid & rx_ready_i;
    assign w_full       = (r_count == DEPTH_C);
    // A pop in the same cycle frees the slot the new word needs.
    assign w_wr         = w_push & (~w_full | w_pop);
    assign w_ovr_set    = w_push & w_full & ~w_pop;
    assign w_rptr_inc   = r_rptr + 1'b1;
    assign w_count_next = r_count + {{FIFO_AW{1'b0}}, w_wr} - {{FIFO_AW{1'b0}}, w_pop};

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= 10'd0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);

            // Head registers follow the next entry; when the FIFO drains they
            // keep the last word.
            if (w_pop) begin
                if (r_count > (FIFO_AW+1)'(1)) begin
                    r_head <= r_mem[w_rptr_inc];
                end else if (w_wr) begin
                    r_head <= w_push_word;
                end
            end else if (!r_valid && w_wr) begin
                r_head <= w_push_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clr_err_i) begin
            r_overrun <= 1'b0;
        end
    end

    assign rx_data_o  = r_head[7:0];
    assign rx_perr_o  = r_head[8];
    assign rx_ferr_o  = r_head[9];
    assign rx_valid_o = r_valid;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Self-checking bench for uart_rx_cfg. Frames are serialised by a driver task;
// the word each frame should leave in the FIFO is queued at send time and
// compared when the receiver presents it on the pop interface.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic [15:0] baud_div_i = 16'd26;
    logic [1:0]  data_bits_i = 2'b11;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        stop2_i = 1'b0;
    logic [7:0]  rx_data_o;
    logic        rx_perr_o;
    logic        rx_ferr_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        break_o;
    logic        overrun_o;
    logic        clr_err_i = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          brk_cnt = 0;
    logic [9:0]  exp_q[$];

    uart_rx_cfg #(.DIV_W(16), .FIFO_AW(2)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .uart_rx_i    (uart_rx_i),
        .baud_div_i   (baud_div_i),
        .data_bits_i  (data_bits_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .rx_data_o    (rx_data_o),
        .rx_perr_o    (rx_perr_o),
        .rx_ferr_o    (rx_ferr_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .break_o      (break_o),
        .overrun_o    (overrun_o),
        .clr_err_i    (clr_err_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (break_o) brk_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic int bit_clks();
        return (int'(baud_div_i) + 1) * 16;
    endfunction

    task automatic idle_bits(input int n);
        uart_rx_i = 1'b1;
        repeat (n * bit_clks()) @(negedge clk_i);
    endtask

    // Serialise one frame with the current configuration. Optionally corrupt
    // the parity bit or drive the first stop bit low. rise_cyc returns the
    // clock count from the start-bit edge to the first rise of rx_valid_o.
    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic bad_stop, input logic expect_push,
                              output int rise_cyc);
        int         nb;
        int         cyc;
        logic       prev;
        logic [7:0] mask;
        logic [7:0] dm;
        logic       bits[$];
        nb   = 5 + int'(data_bits_i);
        mask = 8'hFF >> (8 - nb);
        dm   = d & mask;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
        if (parity_en_i) bits.push_back((^dm) ^ parity_odd_i ^ bad_par);
        bits.push_back(~bad_stop);
        if (stop2_i) bits.push_back(1'b1);
        if (expect_push) exp_q.push_back({bad_stop, bad_par, dm});
        $display("[TB] send 0x%0h bits=%0d par=%0b odd=%0b stop2=%0b bad_par=%0b bad_stop=%0b",
                 dm, nb, parity_en_i, parity_odd_i, stop2_i, bad_par, bad_stop);
        rise_cyc = -1;
        cyc  = 0;
        prev = rx_valid_o;
        for (int b = 0; b < bits.size(); b++) begin
            uart_rx_i = bits[b];
            for (int c = 0; c < bit_clks(); c++) begin
                @(negedge clk_i);
                cyc++;
                if (rise_cyc < 0 && !prev && rx_valid_o) rise_cyc = cyc;
                prev = rx_valid_o;
            end
        end
        uart_rx_i = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        int         w;
        logic [9:0] e;
        w = 0;
        while (!rx_valid_o && w < 5000) begin
            @(negedge clk_i);
            w++;
        end
        if (!rx_valid_o) begin
            chk_eq({tag, "_valid_timeout"}, 32'(rx_valid_o), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk_eq({tag, "_unexpected_word"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk_eq({tag, "_data"}, 32'(rx_data_o), 32'(e[7:0]));
            chk_eq({tag, "_perr"}, 32'(rx_perr_o), 32'(e[8]));
            chk_eq({tag, "_ferr"}, 32'(rx_ferr_o), 32'(e[9]));
        end
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
    endtask

    initial begin
        #600us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        int b0;

        // ---- reset state --------------------------------------------------
        repeat (3) @(negedge clk_i);
        chk_eq("rst_valid",   32'(rx_valid_o), 32'd0);
        chk_eq("rst_break",   32'(break_o),    32'd0);
        chk_eq("rst_overrun", 32'(overrun_o),  32'd0);
        chk_eq("rst_data",    32'(rx_data_o),  32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_i);
        chk_eq("rst_flags", 32'({rx_perr_o, rx_ferr_o}), 32'd0);

        // ---- 8N1 at divisor 26 ----------------------------------------------
        // 2 sync flops + edge flop, then tick k at 3 + k*(div+1); the stop
        // bit's sub-9 decision is tick 16*9+10 and valid follows that edge.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, rise);
        chk_eq("t1_latency", 32'(rise), 32'(3 + (16 * 9 + 10) * 27));
        pop_check("t1_a5");
        chk_eq("t1_valid_after_pop", 32'(rx_valid_o), 32'd0);

        // ---- 7E1 / 5O2 at a faster divisor ------------------------------
        baud_div_i  = 16'd3;
        data_bits_i = 2'b10;
        parity_en_i = 1'b1;
        parity_odd_i = 1'b0;
        idle_bits(1);
        send_frame(8'h41, 1'b0, 1'b0, 1'b1, rise);
        pop_check("t2_7e1_good");
        send_frame(8'h41, 1'b1, 1'b0, 1'b1, rise);
        pop_check("t2_7e1_badpar");
        data_bits_i  = 2'b00;
        parity_odd_i = 1'b1;
        stop2_i      = 1'b1;
        send_frame(8'h15, 1'b0, 1'b0, 1'b1, rise);
        pop_check("t2_5o2");

        // ---- false start -------------------------------------------------
        data_bits_i = 2'b11;
        parity_en_i = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i     = 1'b0;
        idle_bits(1);
        b0 = brk_cnt;
        uart_rx_i = 1'b0;
        repeat (5 * (int'(baud_div_i) + 1)) @(negedge clk_i);
        idle_bits(2);
        chk_eq("t3_glitch_valid", 32'(rx_valid_o), 32'd0);
        chk_eq("t3_glitch_break", 32'(brk_cnt - b0), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, rise);
        pop_check("t3_3c");

        // ---- framing error and break -----------------------------------
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, rise);
        pop_check("t4_ferr");
        idle_bits(1);
        b0 = brk_cnt;
        uart_rx_i = 1'b0;
        repeat (12 * bit_clks()) @(negedge clk_i);
        idle_bits(2);
        chk_eq("t4_break_pulses", 32'(brk_cnt - b0), 32'd1);
        chk_eq("t4_break_valid",  32'(rx_valid_o), 32'd0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, rise);
        pop_check("t4_55");

        // ---- overrun -------------------------------------------------------
        chk_eq("t5_overrun_pre", 32'(overrun_o), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, (i <= 4), rise);
        end
        chk_eq("t5_overrun_set", 32'(overrun_o), 32'd1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("t5_pop%0d", i));
        chk_eq("t5_empty",         32'(rx_valid_o), 32'd0);
        chk_eq("t5_overrun_stick", 32'(overrun_o),  32'd1);
        clr_err_i = 1'b1;
        @(negedge clk_i);
        clr_err_i = 1'b0;
        chk_eq("t5_overrun_clr", 32'(overrun_o), 32'd0);

        // ---- reset mid-DATA with buffered words -----------------------------
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, rise);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, rise);
        chk_eq("t6_buffered", 32'(rx_valid_o), 32'd1);
        uart_rx_i = 1'b0;
        repeat (3 * bit_clks()) @(negedge clk_i);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        uart_rx_i = 1'b1;
        chk_eq("t6_rst_valid",   32'(rx_valid_o), 32'd0);
        chk_eq("t6_rst_overrun", 32'(overrun_o),  32'd0);
        chk_eq("t6_rst_break",   32'(break_o),    32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        idle_bits(2);
        chk_eq("t6_idle_valid", 32'(rx_valid_o), 32'd0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, rise);
        pop_check("t6_7e");
        chk_eq("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Second-generation UART receiver. Supports runtime-configurable baud divisor, 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. Uses 16x oversampling with 3-sample majority voting and detects framing errors, parity errors and break conditions. Received words are buffered in a small show-ahead FIFO with a valid/ready interface toward the platform bus/CPU side, with sticky overrun reporting.

Parameters:
DIV_W, 16, width of baud_div_i
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4)

Ports:
clk_i  input  1  system clock
rst_n  input  1  reset
uart_rx_i  input  1  asynchronous serial line, idle high
baud_div_i  input  DIV_W  oversample tick period minus 1 (tick every baud_div_i+1 clocks); 50 MHz/115200/16 -> 26
data_bits_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en_i  input  1  1 = parity bit present
parity_odd_i  input  1  1 = odd, 0 = even parity
stop2_i  input  1  1 = two stop bits
rx_data_o  output  8  FIFO head data, LSB-aligned, unused upper bits 0
rx_perr_o  output  1  parity error flag of head word
rx_ferr_o  output  1  framing error flag of head word
rx_valid_o  output  1  FIFO not empty
rx_ready_i  input  1  consumer pop; pop occurs when rx_valid_o & rx_ready_i
break_o  output  1  one-cycle pulse on break detection
overrun_o  output  1  sticky: frame dropped because FIFO full
clr_err_i  input  1  clears overrun_o

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk_i. Reset values: all outputs 0, FIFO empty, FSM IDLE, synchronizer flops 1.
- Two-flop synchronizer on uart_rx_i, plus one delay flop for falling-edge detect.
- Config inputs (baud_div_i, data_bits_i, parity_en_i, parity_odd_i, stop2_i) are latched on start-edge detection. Changes mid-frame have no effect on the current frame.
- Tick counter: held at latched divisor in IDLE. Otherwise decrements; tick when 0, then reload. First tick occurs divisor+1 clocks after edge detection.
- 4-bit sub-counter per bit, advanced on tick, 0..15. Samples taken at sub 7, 8, 9; bit value = majority of the 3 samples, decided at sub 9.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
- IDLE -> START on synchronized falling edge.
- START: majority 1 at sub 9 -> IDLE (false start, nothing pushed, no flags). Else at sub 15 -> DATA.
- DATA: shift LSB first. After the Nth bit's sub 15 -> PARITY if parity_en, else STOP.
- PARITY: compute expected = XOR(data) ^ parity_odd. Mismatch sets perr.
- STOP: each stop bit majority-sampled. Any 0 sets ferr. With stop2, the first stop bit runs to sub 15. After the final stop bit's sub-9 decision the frame completes and the FSM returns to IDLE the next cycle, so a start edge during the remaining stop-bit time is accepted.
- Break: data all 0, parity bit 0 (if enabled), and first stop bit 0. Then break_o pulses 1 cycle at completion, nothing is pushed, and the FSM goes to BRKWAIT until the synchronized line is 1, then IDLE.
- Push: the completion cycle writes {ferr, perr, data} into the FIFO. rx_valid_o is high the following cycle.
- FIFO full at completion with no pop that cycle: word dropped, overrun_o set. Full with simultaneous pop: push accepted, no overrun.
- Simultaneous overrun set and clr_err_i: set wins.
- Empty: rx_ready_i ignored, head outputs hold their last values.
- Reset mid-frame: FSM aborts, FIFO emptied, no pulse is generated.

Test Plan:
- 8N1, div=26, send 0xA5 -> rx_data_o=0xA5, perr=ferr=0, rx_valid_o high 1 cycle after final stop sample; pop with ready -> valid=0.
- 7E1, send 0x41 with parity 0 -> data 0x41, perr=0. Same frame with parity 1 -> data 0x41, perr=1. Then 5O2 frame 0x15 -> data 0x15.
- False start: low glitch of 5 ticks -> no push, no flags, next valid 8N1 frame 0x3C received correctly.
- Stop bit driven 0 with data 0x81 -> pushed with ferr=1. Full break (line low for 12 bit times) -> break_o single pulse, FIFO unchanged, next frame 0x55 after line high received.
- Overrun: ready=0, send 5 frames 0x01..0x05 -> FIFO holds 0x01..0x04, overrun_o=1. Pop all four in order; pulse clr_err_i -> overrun_o=0.
- Assert rst_n low mid-DATA with 2 words buffered -> valid=0, overrun=0; next frame 0x7E received cleanly.
